// File: rtl/booth_mul_sched.sv
// booth_mul_sched: radix-2 Booth sequential multiplier shared by NREQ
// requesters through a round-robin front end. One multiplier bit per clock;
// result is held tagged with the requester index until res_ready.
// Optional feature macro: BOOTH_SCHED_ZERO_SKIP_EN (zero operand completes
// on the accept edge with a zero product).
module booth_mul_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*WIDTH-1:0]        res_product,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic                      busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      cur_id;
  logic [WIDTH-1:0]    a_reg, b_reg;
  logic [WIDTH:0]      acc_hi;
  logic [WIDTH-1:0]    acc_lo;
  logic                e;
  logic [CW-1:0]       cnt;

  logic [NREQ-1:0]     win_vec;
  logic [IDW-1:0]      win_id;
  logic                any_valid;
  int unsigned         rr_idx;
  logic                window;
  logic                accept;
  logic                last;
  logic                zero_op;
  logic [WIDTH-1:0]    a_sel, b_sel;
  logic [WIDTH:0]      b_ext, sum;
  logic [WIDTH:0]      hi_nxt;
  logic [WIDTH-1:0]    lo_nxt;

  // Round-robin search starting one past the last granted index
  always_comb begin
    win_vec   = '0;
    win_id    = '0;
    any_valid = 1'b0;
    rr_idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      rr_idx = (32'(ptr) + k) % NREQ;
      if (!any_valid && req_valid[IDW'(rr_idx)]) begin
        any_valid = 1'b1;
        win_id    = IDW'(rr_idx);
      end
    end
    if (any_valid) win_vec = NREQ'(1) << win_id;
  end

  // Grants are suppressed while reset is held so req_ready reads as zero
  assign window    = rst_n && ((state == IDLE) || ((state == DONE) && res_ready));
  assign accept    = window && any_valid;
  assign req_ready = accept ? win_vec : '0;

  assign a_sel = req_a[win_id*WIDTH +: WIDTH];
  assign b_sel = req_b[win_id*WIDTH +: WIDTH];

`ifdef BOOTH_SCHED_ZERO_SKIP_EN
  assign zero_op = (a_sel == '0) || (b_sel == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last      = (state == RUN) && (cnt == CW'(WIDTH-1));
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // One Booth step: add/subtract B on {A[k], e}, then arithmetic shift right
  always_comb begin
    b_ext = {b_reg[WIDTH-1], b_reg};
    sum   = acc_hi;
    case ({a_reg[cnt], e})
      2'b10:   sum = acc_hi - b_ext;
      2'b01:   sum = acc_hi + b_ext;
      default: sum = acc_hi;
    endcase
    hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
    lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_op ? DONE : RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = accept ? (zero_op ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, Booth accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= IDW'(NREQ-1);
      cur_id      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      e           <= 1'b0;
      cnt         <= '0;
      res_product <= '0;
      res_id      <= '0;
    end else if (accept) begin
      a_reg  <= a_sel;
      b_reg  <= b_sel;
      acc_hi <= '0;
      acc_lo <= '0;
      e      <= 1'b0;
      cnt    <= '0;
      cur_id <= win_id;
      ptr    <= win_id;
      if (zero_op) begin
        res_product <= '0;
        res_id      <= win_id;
      end
    end else if (state == RUN) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      e      <= a_reg[cnt];
      cnt    <= cnt + CW'(1);
      if (last) begin
        res_product <= {hi_nxt[WIDTH-1:0], lo_nxt};
        res_id      <= cur_id;
      end
    end
  end

endmodule
